// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM state
// encodings and the baud divider calculation.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   // Clocks per oversample tick, rounded to nearest, never below 1.
   function automatic int calc_div(input longint clk_freq, input longint baud,
                                   input longint oversample);
      longint per_tick;
      longint div;
      per_tick = baud * oversample;
      div      = (clk_freq + per_tick / 2) / per_tick;
      return (div < 1) ? 1 : int'(div);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase
// restartable so each direction can align to its own frame start.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_cfg_transceiver.sv
// Full-duplex UART with configurable framing, a ready/valid transmit port and
// a first-word-fall-through receive FIFO carrying per-word error flags.
module uart_cfg_transceiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int RX_DEPTH   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tx_valid,
   input  logic [DATA_BITS-1:0]        tx_data,
   output logic                        tx_ready,
   output logic                        txd,
   input  logic                        rxd,
   output logic                        rx_valid,
   output logic [DATA_BITS-1:0]        rx_data,
   output logic                        rx_parity_err,
   output logic                        rx_frame_err,
   input  logic                        rx_ready,
   output logic                        rx_overrun,
   input  logic                        ovr_clear,
   output logic [$clog2(RX_DEPTH):0]   rx_count
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int OW  = $clog2(OVERSAMPLE);
   localparam int AW  = $clog2(RX_DEPTH);
   localparam int WW  = DATA_BITS + 2;
   localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0] OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
   localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(RX_DEPTH);

   if (CLK_FREQ < BAUD * OVERSAMPLE) begin : g_bad_clk
      $error("uart_cfg_transceiver: CLK_FREQ below BAUD*OVERSAMPLE");
   end
   if ((OVERSAMPLE != 8 && OVERSAMPLE != 16) || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
       RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("uart_cfg_transceiver: unsupported parameter combination");
   end

   // ---------------- transmitter ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic [OW-1:0]        tx_os_q, tx_os_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic                 txd_q, txd_d;
   logic                 tx_accept, tx_tick;

   assign tx_ready  = (tx_state_q == TX_IDLE);
   assign tx_accept = tx_valid & tx_ready;
   assign txd       = txd_q;

   uart_baud_tick #(.DIV(DIV)) u_tx_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (tx_accept),
      .tick    (tx_tick)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_os_d    = tx_os_q;
      tx_bit_d   = tx_bit_q;
      if (tx_state_q == TX_IDLE) begin
         if (tx_valid) begin
            tx_state_d = TX_START;
            tx_shift_d = tx_data;
            tx_par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
            tx_os_d    = '0;
            tx_bit_d   = '0;
         end
      end else if (tx_tick) begin
         if (tx_os_q != OS_LAST) begin
            tx_os_d = tx_os_q + 1'b1;
         end else begin
            tx_os_d = '0;
            case (tx_state_q)
               TX_START: tx_state_d = TX_DATA;
               TX_DATA: begin
                  tx_shift_d = tx_shift_q >> 1;
                  if (tx_bit_q == DB_LAST) begin
                     tx_bit_d   = '0;
                     tx_state_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                  end else begin
                     tx_bit_d = tx_bit_q + 1'b1;
                  end
               end
               TX_PARITY: tx_state_d = TX_STOP;
               TX_STOP: begin
                  if (tx_bit_q == SB_LAST) tx_state_d = TX_IDLE;
                  else                     tx_bit_d   = tx_bit_q + 1'b1;
               end
               default: tx_state_d = TX_IDLE;
            endcase
         end
      end
      // Line level follows the next state so txd can be a plain flop.
      case (tx_state_d)
         TX_START:  txd_d = 1'b0;
         TX_DATA:   txd_d = tx_shift_d[0];
         TX_PARITY: txd_d = tx_par_d;
         default:   txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_os_q    <= '0;
         tx_bit_q   <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_os_q    <= tx_os_d;
         tx_bit_q   <= tx_bit_d;
         txd_q      <= txd_d;
      end
   end

   // ---------------- receiver ----------------
   logic [1:0]           sync_q;
   logic                 rxs;
   rx_state_e            rx_state_q, rx_state_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_perr_q, rx_perr_d;
   logic [OW-1:0]        rx_os_q, rx_os_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic                 rx_restart, rx_tick, push;
   logic [WW-1:0]        push_word;

   assign rxs = sync_q[1];

   uart_baud_tick #(.DIV(DIV)) u_rx_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (rx_restart),
      .tick    (rx_tick)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_perr_d  = rx_perr_q;
      rx_os_d    = rx_os_q;
      rx_bit_d   = rx_bit_q;
      rx_restart = 1'b0;
      push       = 1'b0;
      push_word  = {~rxs, (PARITY != PAR_NONE) & rx_perr_q, rx_shift_q};
      case (rx_state_q)
         RX_IDLE: begin
            if (!rxs) begin
               rx_state_d = RX_START;
               rx_restart = 1'b1;
               rx_os_d    = '0;
            end
         end
         RX_BREAK: if (rxs) rx_state_d = RX_IDLE;
         default: begin
            if (rx_tick) begin
               if (rx_state_q == RX_START && rx_os_q == OS_HALF) begin
                  rx_os_d    = '0;
                  rx_bit_d   = '0;
                  rx_perr_d  = 1'b0;
                  rx_state_d = rxs ? RX_IDLE : RX_DATA;
               end else if (rx_state_q != RX_START && rx_os_q == OS_LAST) begin
                  rx_os_d = '0;
                  case (rx_state_q)
                     RX_DATA: begin
                        rx_shift_d = {rxs, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == DB_LAST)
                           rx_state_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
                        else
                           rx_bit_d = rx_bit_q + 1'b1;
                     end
                     RX_PARITY: begin
                        rx_perr_d  = rxs != ((PARITY == PAR_ODD) ? ~^rx_shift_q : ^rx_shift_q);
                        rx_state_d = RX_STOP;
                     end
                     RX_STOP: begin
                        push       = 1'b1;
                        rx_state_d = rxs ? RX_IDLE : RX_BREAK;
                     end
                     default: rx_state_d = RX_IDLE;
                  endcase
               end else begin
                  rx_os_d = rx_os_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= 2'b11;
         rx_state_q <= RX_IDLE;
         rx_shift_q <= '0;
         rx_perr_q  <= 1'b0;
         rx_os_q    <= '0;
         rx_bit_q   <= '0;
      end else begin
         sync_q     <= {sync_q[0], rxd};
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_perr_q  <= rx_perr_d;
         rx_os_q    <= rx_os_d;
         rx_bit_q   <= rx_bit_d;
      end
   end

   // ---------------- receive FIFO ----------------
   logic [WW-1:0] mem_q [RX_DEPTH];
   logic [AW:0]   wr_q, rd_q;
   logic          ovr_q;
   logic          full, pop, do_push;
   logic [WW-1:0] head_word;

   assign rx_count  = wr_q - rd_q;
   assign rx_valid  = (rx_count != '0);
   assign full      = (rx_count == DEPTH_C);
   assign pop       = rx_valid & rx_ready;
   assign do_push   = push & (~full | pop);
   assign head_word = mem_q[rd_q[AW-1:0]];

   // Head fields read as zero when empty so outputs match their reset values.
   assign rx_data       = rx_valid ? head_word[DATA_BITS-1:0] : '0;
   assign rx_parity_err = rx_valid & head_word[DATA_BITS];
   assign rx_frame_err  = rx_valid & head_word[DATA_BITS+1];
   assign rx_overrun    = ovr_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovr_q <= 1'b0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (pop)     rd_q <= rd_q + 1'b1;
         if (push && full && !pop) ovr_q <= 1'b1;
         else if (ovr_clear)       ovr_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_cfg_transceiver.sv
// Self-checking bench: 16-clock bits, 8E1 framing, 4-entry receive FIFO,
// expectations from a frame-level line model and a word queue.
module tb_uart_cfg_transceiver;

   localparam int DB  = 8;
   localparam int BIT = 16;
   localparam int FRM = 11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, txd;
   logic       rxd;
   logic       rxd_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_parity_err, rx_frame_err, rx_overrun;
   logic       rx_ready = 1'b0;
   logic       ovr_clear = 1'b0;
   logic [2:0] rx_count;

   int checks = 0;
   int failures = 0;
   logic [9:0] model_q[$];   // {frame_err, parity_err, data}
   logic       model_ovr = 1'b0;

   always #5 clk = ~clk;
   assign rxd = loop_en ? txd : rxd_drv;

   uart_cfg_transceiver #(
      .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(8),
      .PARITY(2), .STOP_BITS(1), .RX_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .txd(txd), .rxd(rxd), .rx_valid(rx_valid),
      .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
      .rx_ready(rx_ready), .rx_overrun(rx_overrun), .ovr_clear(ovr_clear),
      .rx_count(rx_count)
   );

   // Line level of bit i of an 8-data-bit frame (start, data LSB first, parity, stop).
   function automatic logic line_bit(input logic [7:0] d, input logic par,
                                     input logic stop, input int i);
      if (i == 0) return 1'b0;
      if (i <= DB) return d[i-1];
      if (i == DB + 1) return par;
      return stop;
   endfunction

   task automatic tx_frame(input logic [7:0] d, input string tag);
      logic exp;
      @(negedge clk);
      checks++;
      if (tx_ready !== 1'b1 || txd !== 1'b1) begin
         failures++;
         $display("FAIL %s_idle: got ready=%b txd=%b want ready=1 txd=1", tag, tx_ready, txd);
      end
      tx_valid = 1'b1;
      tx_data  = d;
      for (int k = 0; k < FRM * BIT; k++) begin
         @(negedge clk);
         if (k == 0) tx_valid = 1'b0;
         exp = line_bit(d, ^d, 1'b1, k / BIT);
         checks++;
         if (txd !== exp || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_txd cycle %0d: got txd=%b ready=%b want txd=%b ready=0",
                     tag, k, txd, tx_ready, exp);
         end
      end
   endtask

   task automatic rx_drive(input logic [7:0] d, input logic bad_par,
                           input logic stop, input int hold_low);
      for (int i = 0; i < FRM; i++) begin
         rxd_drv = line_bit(d, (^d) ^ bad_par, stop, i);
         repeat (BIT) @(negedge clk);
      end
      repeat (hold_low) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (4) @(negedge clk);
      if (model_q.size() < 4) model_q.push_back({~stop, bad_par, d});
      else                    model_ovr = 1'b1;
   endtask

   task automatic check_count(input string tag);
      checks++;
      if (rx_count !== 3'(model_q.size())) begin
         failures++;
         $display("FAIL %s_count: got %0d want %0d", tag, rx_count, model_q.size());
      end
   endtask

   task automatic drain(input string tag);
      logic [9:0] e;
      while (model_q.size() > 0) begin
         e = model_q.pop_front();
         checks++;
         if (rx_valid !== 1'b1 || rx_data !== e[7:0] || rx_parity_err !== e[8] ||
             rx_frame_err !== e[9]) begin
            failures++;
            $display("FAIL %s_head: got v=%b d=%h pe=%b fe=%b want v=1 d=%h pe=%b fe=%b",
                     tag, rx_valid, rx_data, rx_parity_err, rx_frame_err, e[7:0], e[8], e[9]);
         end
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
      end
      checks++;
      if (rx_valid !== 1'b0 || rx_count !== 3'd0) begin
         failures++;
         $display("FAIL %s_empty: got v=%b count=%0d want v=0 count=0", tag, rx_valid, rx_count);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (txd !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00 ||
          rx_parity_err !== 1'b0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0 ||
          rx_count !== 3'd0) begin
         failures++;
         $display("FAIL %s: got txd=%b rdy=%b v=%b d=%h pe=%b fe=%b ovr=%b cnt=%0d want 1 1 0 00 0 0 0 0",
                  tag, txd, tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err,
                  rx_overrun, rx_count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_reset_values("after_reset_idle");
   endtask

   task automatic test_back_to_back();
      tx_frame(8'hA5, "tx_a5");
      tx_frame(8'($urandom), "tx_b2b1");
      tx_frame(8'($urandom), "tx_b2b2");
      @(negedge clk);
      checks++;
      if (tx_ready !== 1'b1) begin
         failures++;
         $display("FAIL tx_ready_return: got %b want 1", tx_ready);
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_loopback();
      loop_en = 1'b1;
      tx_frame(8'h3C, "loop_tx");
      model_q.push_back({2'b00, 8'h3C});
      @(negedge clk);
      loop_en = 1'b0;
      check_count("loop");
      drain("loop");
   endtask

   task automatic test_parity();
      rx_drive(8'h01, 1'b1, 1'b1, 0);
      rx_drive(8'h02, 1'b0, 1'b1, 0);
      check_count("parity");
      drain("parity");
   endtask

   task automatic test_frame_error();
      rx_drive(8'h55, 1'b0, 1'b0, 40);
      check_count("break");
      rx_drive(8'h0F, 1'b0, 1'b1, 0);
      check_count("after_break");
      drain("frame_err");
   endtask

   task automatic test_glitch();
      rxd_drv = 1'b0;
      repeat (4) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (40) @(negedge clk);
      check_count("glitch");
      rx_drive(8'($urandom), 1'b0, 1'b1, 0);
      check_count("post_glitch");
      drain("post_glitch");
   endtask

   task automatic test_overrun();
      model_ovr = 1'b0;
      for (int i = 0; i < 5; i++) rx_drive(8'h10 + 8'(i), 1'b0, 1'b1, 0);
      check_count("overrun");
      checks++;
      if (rx_overrun !== model_ovr) begin
         failures++;
         $display("FAIL overrun_set: got %b want %b", rx_overrun, model_ovr);
      end
      drain("overrun");
      checks++;
      if (rx_overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_sticky: got %b want 1", rx_overrun);
      end
      ovr_clear = 1'b1;
      @(negedge clk);
      ovr_clear = 1'b0;
      model_ovr = 1'b0;
      checks++;
      if (rx_overrun !== model_ovr) begin
         failures++;
         $display("FAIL overrun_clear: got %b want 0", rx_overrun);
      end
   endtask

   task automatic test_reset_mid_frame();
      rx_drive(8'h77, 1'b0, 1'b1, 0);
      check_count("pre_rst");
      loop_en  = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (60) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("reset_mid_frame");
      rst = 1'b0;
      model_q.delete();
      repeat (200) @(negedge clk);
      loop_en = 1'b0;
      check_count("post_rst_quiet");
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       bad;
      for (int n = 0; n < 10; n++) begin
         d   = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         rx_drive(d, bad, 1'b1, 0);
         check_count("rand");
         if ($urandom_range(0, 1) == 1 || model_q.size() == 4) drain("rand");
      end
      drain("rand_final");
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_loopback();
      test_parity();
      test_frame_error();
      test_glitch();
      test_overrun();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
